knn_box_dispatch: RTL and testbench

//  Initiator side of the KNN image engine (knn_img) handshake. Buffers bounding boxes from upstream

---
 rtl/knn_pkg.sv | 9 +
 rtl/knn_box_fifo.sv | 35 +++
 rtl/knn_box_dispatch.sv | 129 ++++++++++++
 tb/tb_knn_box_dispatch.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/knn_pkg.sv
// knn_pkg: shared widths, FSM encoding and record sizing for the KNN box dispatcher
package knn_pkg;
  localparam int KNN_COORD_W = 10;
  localparam int KNN_CNT_W = 4;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESULT} state_t;
  function automatic int box_rec_w(input int coord_w, input int tag_w);
    return 1 + tag_w + 4 * coord_w;
  endfunction
endpackage

// File: rtl/knn_box_fifo.sv
// knn_box_fifo: synchronous show-ahead FIFO holding normalised boxes with their tags
module knn_box_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 45
) (
  input  logic         clk_en,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign dout = mem[rp];
  always_ff @(posedge clk_en)
    if (push) mem[wp] <= din;
  always_ff @(posedge clk_en) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      wp <= wp + AW'(push);
      rp <= rp + AW'(pop);
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: rtl/knn_box_dispatch.sv
// knn_box_dispatch: queues boxes, issues them to knn_img and returns tagged results.
// Optional WAIT watchdog enabled by defining KNN_DISPATCH_TIMEOUT_EN.
module knn_box_dispatch
  import knn_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int COORD_W = KNN_COORD_W,
  parameter int TAG_W = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                 clk_en,
  input  logic                 reset,
  input  logic                 dic_ready_i,
  input  logic                 box_valid_i,
  output logic                 box_ready_o,
  input  logic [COORD_W-1:0]   box_lu_x_i,
  input  logic [COORD_W-1:0]   box_lu_y_i,
  input  logic [COORD_W-1:0]   box_rd_x_i,
  input  logic [COORD_W-1:0]   box_rd_y_i,
  output logic [COORD_W-1:0]   postion_lu_x_o,
  output logic [COORD_W-1:0]   postion_lu_y_o,
  output logic [COORD_W-1:0]   postion_rd_x_o,
  output logic [COORD_W-1:0]   postion_rd_y_o,
  output logic                 knn_en_o,
  output logic                 dic_end_o,
  input  logic                 knn_fin_i,
  input  logic [KNN_CNT_W-1:0] cnt_w_i,
  input  logic [KNN_CNT_W-1:0] cnt_h_i,
  input  logic [COORD_W-1:0]   wid_center_i,
  input  logic [COORD_W-1:0]   hei_center_i,
  output logic                 res_valid_o,
  input  logic                 res_ready_i,
  output logic [KNN_CNT_W-1:0] res_cnt_w_o,
  output logic [KNN_CNT_W-1:0] res_cnt_h_o,
  output logic [COORD_W-1:0]   res_wid_center_o,
  output logic [COORD_W-1:0]   res_hei_center_o,
  output logic [TAG_W-1:0]     res_tag_o,
  output logic                 res_err_o,
  output logic                 busy_o
);
  localparam int RW = box_rec_w(COORD_W, TAG_W);
  state_t state, nxt;
  logic push, pop, full, empty, fin_q, fin_edge, tmo, issue, degen, h_degen;
  logic [TAG_W-1:0] tag_cnt, h_tag;
  logic [COORD_W-1:0] lu_x, lu_y, rd_x, rd_y;
  logic [COORD_W-1:0] h_lu_x, h_lu_y, h_rd_x, h_rd_y;
  logic [COORD_W-1:0] p_lu_x, p_lu_y, p_rd_x, p_rd_y;
  logic [RW-1:0] din, dout;
  // lu is the top edge, so it takes the larger y
  assign lu_x = box_lu_x_i < box_rd_x_i ? box_lu_x_i : box_rd_x_i;
  assign rd_x = box_lu_x_i < box_rd_x_i ? box_rd_x_i : box_lu_x_i;
  assign lu_y = box_lu_y_i > box_rd_y_i ? box_lu_y_i : box_rd_y_i;
  assign rd_y = box_lu_y_i > box_rd_y_i ? box_rd_y_i : box_lu_y_i;
  assign degen = box_lu_x_i == box_rd_x_i || box_lu_y_i == box_rd_y_i;
  assign din = {degen, tag_cnt, lu_x, lu_y, rd_x, rd_y};
  assign {h_degen, h_tag, h_lu_x, h_lu_y, h_rd_x, h_rd_y} = dout;
  assign issue = state == S_ISSUE;
  assign pop = issue;
  assign box_ready_o = ~reset & (~full | pop);
  assign push = box_valid_i & box_ready_o;
  assign knn_en_o = issue & ~h_degen;
  assign postion_lu_x_o = issue ? h_lu_x : p_lu_x;
  assign postion_lu_y_o = issue ? h_lu_y : p_lu_y;
  assign postion_rd_x_o = issue ? h_rd_x : p_rd_x;
  assign postion_rd_y_o = issue ? h_rd_y : p_rd_y;
  assign fin_edge = knn_fin_i & ~fin_q;
  assign res_valid_o = state == S_RESULT;
  assign busy_o = state != S_IDLE;
  knn_box_fifo #(.DEPTH(FIFO_DEPTH), .W(RW)) u_fifo (
    .clk_en(clk_en),
    .reset(reset),
    .push(push),
    .pop(pop),
    .din(din),
    .dout(dout),
    .full(full),
    .empty(empty)
  );
`ifdef KNN_DISPATCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC);
  logic [TW-1:0] wcnt;
  assign tmo = state == S_WAIT && wcnt == TW'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk_en)
    wcnt <= (reset || state != S_WAIT) ? '0 : wcnt + 1'b1;
`else
  assign tmo = 1'b0;
`endif
  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:   nxt = (!empty && dic_end_o) ? S_ISSUE : S_IDLE;
      S_ISSUE:  nxt = h_degen ? S_RESULT : S_WAIT;
      S_WAIT:   nxt = (fin_edge || tmo) ? S_RESULT : S_WAIT;
      S_RESULT: nxt = res_ready_i ? S_IDLE : S_RESULT;
      default:  nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk_en) begin
    if (reset) begin
      state <= S_IDLE;
      dic_end_o <= 1'b0;
      fin_q <= 1'b0;
      tag_cnt <= '0;
      {p_lu_x, p_lu_y, p_rd_x, p_rd_y} <= '0;
      {res_cnt_w_o, res_cnt_h_o, res_wid_center_o, res_hei_center_o} <= '0;
      res_tag_o <= '0;
      res_err_o <= 1'b0;
    end else begin
      state <= nxt;
      dic_end_o <= dic_ready_i;
      fin_q <= knn_fin_i;
      tag_cnt <= tag_cnt + TAG_W'(push);
      if (issue) begin
        {p_lu_x, p_lu_y, p_rd_x, p_rd_y} <= {h_lu_x, h_lu_y, h_rd_x, h_rd_y};
        {res_cnt_w_o, res_cnt_h_o, res_wid_center_o, res_hei_center_o} <= '0;
        res_tag_o <= h_tag;
        res_err_o <= h_degen;
      end
      // a fin edge wins over a watchdog expiry in the same cycle
      if (state == S_WAIT && fin_edge) begin
        {res_cnt_w_o, res_cnt_h_o} <= {cnt_w_i, cnt_h_i};
        {res_wid_center_o, res_hei_center_o} <= {wid_center_i, hei_center_i};
        res_err_o <= 1'b0;
      end else if (tmo) begin
        res_err_o <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_knn_box_dispatch.sv
// tb_knn_box_dispatch: directed self-checking bench for knn_box_dispatch
module tb_knn_box_dispatch;
  logic clk_en = 1'b0;
  logic reset, dic_ready, box_valid, box_ready, knn_en, dic_end, knn_fin;
  logic res_valid, res_ready, res_err, busy;
  logic [9:0] bx0, by0, bx1, by1, pos_lu_x, pos_lu_y, pos_rd_x, pos_rd_y;
  logic [9:0] wid, hei, res_wid, res_hei;
  logic [3:0] cnt_w, cnt_h, res_cnt_w, res_cnt_h, res_tag;
  int checks = 0;
  int errors = 0;
  int pulses;
  always #5 clk_en = ~clk_en;
  knn_box_dispatch #(.FIFO_DEPTH(4), .COORD_W(10), .TAG_W(4), .TIMEOUT_CYC(64)) dut (
    .clk_en(clk_en),
    .reset(reset),
    .dic_ready_i(dic_ready),
    .box_valid_i(box_valid),
    .box_ready_o(box_ready),
    .box_lu_x_i(bx0),
    .box_lu_y_i(by0),
    .box_rd_x_i(bx1),
    .box_rd_y_i(by1),
    .postion_lu_x_o(pos_lu_x),
    .postion_lu_y_o(pos_lu_y),
    .postion_rd_x_o(pos_rd_x),
    .postion_rd_y_o(pos_rd_y),
    .knn_en_o(knn_en),
    .dic_end_o(dic_end),
    .knn_fin_i(knn_fin),
    .cnt_w_i(cnt_w),
    .cnt_h_i(cnt_h),
    .wid_center_i(wid),
    .hei_center_i(hei),
    .res_valid_o(res_valid),
    .res_ready_i(res_ready),
    .res_cnt_w_o(res_cnt_w),
    .res_cnt_h_o(res_cnt_h),
    .res_wid_center_o(res_wid),
    .res_hei_center_o(res_hei),
    .res_tag_o(res_tag),
    .res_err_o(res_err),
    .busy_o(busy)
  );
  task automatic tick;
    @(posedge clk_en);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic set_box(input int a, input int b, input int c, input int d);
    bx0 = 10'(a);
    by0 = 10'(b);
    bx1 = 10'(c);
    by1 = 10'(d);
  endtask
  task automatic chk_pos(input string tag, input int a, input int b, input int c, input int d);
    chk({tag, "_lu_x"}, pos_lu_x, a);
    chk({tag, "_lu_y"}, pos_lu_y, b);
    chk({tag, "_rd_x"}, pos_rd_x, c);
    chk({tag, "_rd_y"}, pos_rd_y, d);
  endtask
  task automatic accept;
    res_ready = 1'b1;
    tick;
    res_ready = 1'b0;
  endtask
  initial begin
    reset = 1'b1;
    dic_ready = 1'b1;
    box_valid = 1'b0;
    knn_fin = 1'b0;
    res_ready = 1'b0;
    set_box(0, 0, 0, 0);
    {cnt_w, cnt_h, wid, hei} = '0;
    tick;
    chk("rst_box_ready", box_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_knn_en", knn_en, 0);
    chk("rst_dic_end", dic_end, 0);
    chk_pos("rst_pos", 0, 0, 0, 0);
    reset = 1'b0;
    tick;
    tick;
    chk("dic_end_follow", dic_end, 1);
    chk("idle_box_ready", box_ready, 1);
    // test 1: ordered box, fin 50 cycles after start
    set_box(100, 400, 300, 200);
    box_valid = 1'b1;
    tick;
    box_valid = 1'b0;
    chk("t1_en_n1", knn_en, 0);
    tick;
    chk("t1_en_n2", knn_en, 1);
    chk_pos("t1_pos", 100, 400, 300, 200);
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      tick;
      if (knn_en) pulses++;
    end
    chk("t1_extra_pulses", pulses, 0);
    chk_pos("t1_hold", 100, 400, 300, 200);
    chk("t1_busy", busy, 1);
    chk("t1_no_res", res_valid, 0);
    cnt_w = 3;
    cnt_h = 2;
    wid = 150;
    hei = 300;
    knn_fin = 1'b1;
    tick;
    knn_fin = 1'b0;
    chk("t1_res_valid", res_valid, 1);
    chk("t1_cnt_w", res_cnt_w, 3);
    chk("t1_cnt_h", res_cnt_h, 2);
    chk("t1_wid", res_wid, 150);
    chk("t1_hei", res_hei, 300);
    chk("t1_tag", res_tag, 0);
    chk("t1_err", res_err, 0);
    cnt_w = 0;
    tick;
    chk("t1_hold_valid", res_valid, 1);
    chk("t1_hold_cnt_w", res_cnt_w, 3);
    accept;
    chk("t1_done_valid", res_valid, 0);
    chk("t1_done_busy", busy, 0);
    // test 2: swapped corners normalise to the same box
    set_box(300, 200, 100, 400);
    box_valid = 1'b1;
    tick;
    box_valid = 1'b0;
    tick;
    chk("t2_en", knn_en, 1);
    chk_pos("t2_pos", 100, 400, 300, 200);
    tick;
    cnt_w = 5;
    knn_fin = 1'b1;
    tick;
    knn_fin = 1'b0;
    chk("t2_valid", res_valid, 1);
    chk("t2_tag", res_tag, 1);
    chk("t2_cnt_w", res_cnt_w, 5);
    dic_ready = 1'b0;
    accept;
    tick;
    chk("t3_dic_low", dic_end, 0);
    // test 3: five boxes into a stalled engine
    for (int i = 0; i < 5; i++) begin
      set_box(10, 100, 20 + i, 50);
      box_valid = 1'b1;
      chk($sformatf("t3_ready_%0d", i), box_ready, (i < 4) ? 1 : 0);
      tick;
    end
    chk("t3_full_ready", box_ready, 0);
    chk("t3_stall_en", knn_en, 0);
    chk("t3_stall_busy", busy, 0);
    dic_ready = 1'b1;
    tick;
    chk("t3_idle_ready", box_ready, 0);
    tick;
    chk("t3_issue_ready", box_ready, 1);
    chk("t3_issue_en", knn_en, 1);
    chk_pos("t3_pos0", 10, 100, 20, 50);
    tick;
    box_valid = 1'b0;
    chk("t3_refull_ready", box_ready, 0);
    for (int j = 0; j < 5; j++) begin
      cnt_w = 4'(j);
      cnt_h = 4'(j + 1);
      wid = 10'(10 * j + 7);
      hei = 10'(20 * j + 9);
      knn_fin = 1'b1;
      tick;
      knn_fin = 1'b0;
      chk($sformatf("t3_valid_%0d", j), res_valid, 1);
      chk($sformatf("t3_tag_%0d", j), res_tag, 2 + j);
      chk($sformatf("t3_cnt_w_%0d", j), res_cnt_w, j);
      chk($sformatf("t3_wid_%0d", j), res_wid, 10 * j + 7);
      accept;
      if (j < 4) begin
        tick;
        chk($sformatf("t3_en_%0d", j + 1), knn_en, 1);
        chk($sformatf("t3_rd_x_%0d", j + 1), pos_rd_x, 21 + j);
        tick;
      end
    end
    chk("t3_drained_busy", busy, 0);
    // test 4: degenerate box then a normal one
    cnt_w = 9;
    wid = 77;
    set_box(50, 80, 50, 20);
    box_valid = 1'b1;
    tick;
    set_box(100, 400, 300, 200);
    tick;
    box_valid = 1'b0;
    chk("t4_deg_no_en", knn_en, 0);
    chk("t4_deg_busy", busy, 1);
    tick;
    chk("t4_deg_valid", res_valid, 1);
    chk("t4_deg_err", res_err, 1);
    chk("t4_deg_cnt_w", res_cnt_w, 0);
    chk("t4_deg_cnt_h", res_cnt_h, 0);
    chk("t4_deg_wid", res_wid, 0);
    chk("t4_deg_hei", res_hei, 0);
    chk("t4_deg_tag", res_tag, 7);
    accept;
    tick;
    chk("t4_next_en", knn_en, 1);
    chk_pos("t4_next_pos", 100, 400, 300, 200);
    tick;
    cnt_w = 6;
    knn_fin = 1'b1;
    tick;
    knn_fin = 1'b0;
    chk("t4_next_valid", res_valid, 1);
    chk("t4_next_err", res_err, 0);
    chk("t4_next_cnt_w", res_cnt_w, 6);
    chk("t4_next_tag", res_tag, 8);
    accept;
    // test 5: fin already high before ISSUE
    knn_fin = 1'b1;
    cnt_w = 7;
    set_box(200, 10, 20, 300);
    box_valid = 1'b1;
    tick;
    box_valid = 1'b0;
    tick;
    chk("t5_en", knn_en, 1);
    chk_pos("t5_pos", 20, 300, 200, 10);
    for (int i = 0; i < 6; i++) tick;
    chk("t5_held_no_res", res_valid, 0);
    knn_fin = 1'b0;
    tick;
    chk("t5_low_no_res", res_valid, 0);
    cnt_w = 9;
    cnt_h = 1;
    wid = 33;
    hei = 44;
    knn_fin = 1'b1;
    tick;
    knn_fin = 1'b0;
    chk("t5_valid", res_valid, 1);
    chk("t5_cnt_w", res_cnt_w, 9);
    chk("t5_wid", res_wid, 33);
    chk("t5_tag", res_tag, 9);
    accept;
`ifdef KNN_DISPATCH_TIMEOUT_EN
    // test 6a: watchdog with no fin
    set_box(1, 2, 3, 4);
    box_valid = 1'b1;
    tick;
    box_valid = 1'b0;
    tick;
    tick;
    for (int i = 0; i < 63; i++) tick;
    chk("t6_before_tmo", res_valid, 0);
    tick;
    chk("t6_tmo_valid", res_valid, 1);
    chk("t6_tmo_err", res_err, 1);
    chk("t6_tmo_cnt_w", res_cnt_w, 0);
    chk("t6_tmo_wid", res_wid, 0);
    chk("t6_tmo_tag", res_tag, 10);
    accept;
`endif
    // test 6b: reset while waiting, with a second box queued
    set_box(5, 90, 60, 30);
    box_valid = 1'b1;
    tick;
    set_box(6, 91, 61, 31);
    tick;
    box_valid = 1'b0;
    chk("t6_pre_en", knn_en, 1);
    tick;
    chk("t6_pre_busy", busy, 1);
    reset = 1'b1;
    tick;
    chk("t6_rst_box_ready", box_ready, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_valid", res_valid, 0);
    chk("t6_rst_en", knn_en, 0);
    chk("t6_rst_dic_end", dic_end, 0);
    chk("t6_rst_tag", res_tag, 0);
    chk("t6_rst_err", res_err, 0);
    chk("t6_rst_cnt_w", res_cnt_w, 0);
    chk("t6_rst_wid", res_wid, 0);
    chk_pos("t6_rst_pos", 0, 0, 0, 0);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (knn_en) pulses++;
    end
    chk("t6_no_reissue", pulses, 0);
    chk("t6_post_busy", busy, 0);
    chk("t6_post_ready", box_ready, 1);
    set_box(7, 70, 17, 17);
    box_valid = 1'b1;
    tick;
    box_valid = 1'b0;
    tick;
    chk("t6_post_en", knn_en, 1);
    tick;
    cnt_w = 2;
    knn_fin = 1'b1;
    tick;
    knn_fin = 1'b0;
    chk("t6_post_valid", res_valid, 1);
    chk("t6_post_tag", res_tag, 0);
    chk("t6_post_cnt_w", res_cnt_w, 2);
    accept;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
